// File: rtl/ball_engine.sv
// ball_engine: pong ball motion, wall/paddle bounces, scoring and serve/point/game-over FSM.
// Optional feature macro BALL_ENGINE_SPEEDUP_EN: each valid paddle hit raises speed up to MAX_SPD.
module ball_engine #(
   parameter int X_W       = 10,
   parameter int Y_W       = 10,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int BALL_SZ   = 8,
   parameter int SPD_W     = 4,
   parameter int INIT_SPD  = 4,
   parameter int MAX_SPD   = 12,
   parameter int HOLD_FR   = 60,
   parameter int SCORE_W   = 4,
   parameter int WIN_SCORE = 9
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               frame_tick,
   input  logic               serve,
   input  logic               hit_l,
   input  logic               hit_r,
   output logic [X_W-1:0]     ball_x,
   output logic [Y_W-1:0]     ball_y,
   output logic               dir_x,
   output logic               dir_y,
   output logic [SPD_W-1:0]   speed,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               point_l,
   output logic               point_r,
   output logic [1:0]         state
);
   localparam int                   XMAX      = SCREEN_W - BALL_SZ;
   localparam int                   YMAX      = SCREEN_H - BALL_SZ;
   localparam int                   HOLD_W    = $clog2(HOLD_FR + 1);
   localparam logic [X_W-1:0]       X_MID     = X_W'(XMAX / 2);
   localparam logic [Y_W-1:0]       Y_MID     = Y_W'(YMAX / 2);
   localparam logic [X_W-1:0]       X_LIM     = X_W'(XMAX);
   localparam logic [Y_W-1:0]       Y_LIM     = Y_W'(YMAX);
   localparam logic signed [X_W:0]  X_TOP     = (X_W + 1)'(XMAX);
   localparam logic signed [Y_W:0]  Y_TOP     = (Y_W + 1)'(YMAX);
   localparam logic [SPD_W-1:0]     SPD_INIT  = SPD_W'(INIT_SPD);
   localparam logic [SCORE_W-1:0]   SCORE_WIN = SCORE_W'(WIN_SCORE);

   if (MAX_SPD > (1 << SPD_W) - 1 || WIN_SCORE > (1 << SCORE_W) - 1) begin : g_bad_cfg
      $error("ball_engine: MAX_SPD or WIN_SCORE exceeds its register width");
   end

   typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

   state_t                st, st_d;
   logic [X_W-1:0]        x_d;
   logic [Y_W-1:0]        y_d;
   logic                  dx_d, dy_d, pl_d, pr_d;
   logic [SCORE_W-1:0]    sl_d, sr_d;
   logic [HOLD_W-1:0]     hold, hold_d;
   logic                  hit_ok, ndx;
   logic [SPD_W-1:0]      nspd;
   logic signed [X_W:0]   nx, sx;
   logic signed [Y_W:0]   ny, sy;

   assign state  = st;
   assign hit_ok = dir_x ? hit_r : hit_l;
   assign ndx    = dir_x ^ hit_ok;

`ifdef BALL_ENGINE_SPEEDUP_EN
   logic [SPD_W-1:0] spd_d;
   assign nspd = (hit_ok && speed < SPD_W'(MAX_SPD)) ? speed + SPD_W'(1) : speed;
`else
   assign speed = SPD_INIT;
   assign nspd  = speed;
`endif

   assign sx = $signed({{(X_W + 1 - SPD_W){1'b0}}, nspd});
   assign sy = $signed({{(Y_W + 1 - SPD_W){1'b0}}, nspd});
   assign nx = ndx ? $signed({1'b0, ball_x}) + sx : $signed({1'b0, ball_x}) - sx;
   assign ny = dir_y ? $signed({1'b0, ball_y}) + sy : $signed({1'b0, ball_y}) - sy;

   // next-state and datapath update for the serve/play/point/over sequence
   always_comb begin
      st_d   = st;
      x_d    = ball_x;
      y_d    = ball_y;
      dx_d   = dir_x;
      dy_d   = dir_y;
      sl_d   = score_l;
      sr_d   = score_r;
      pl_d   = 1'b0;
      pr_d   = 1'b0;
      hold_d = hold;
`ifdef BALL_ENGINE_SPEEDUP_EN
      spd_d  = speed;
`endif
      case (st)
         SERVE: if (serve) st_d = PLAY;
         PLAY: if (frame_tick) begin
            dx_d = ndx;
`ifdef BALL_ENGINE_SPEEDUP_EN
            spd_d = nspd;
`endif
            y_d  = ny[Y_W] ? '0 : (ny > Y_TOP) ? Y_LIM : ny[Y_W-1:0];
            dy_d = ny[Y_W] ? 1'b1 : (ny > Y_TOP) ? 1'b0 : dir_y;
            if (!hit_ok && nx[X_W]) begin
               x_d    = '0;
               sr_d   = score_r + SCORE_W'(1);
               pr_d   = 1'b1;
               hold_d = '0;
               st_d   = (sr_d == SCORE_WIN) ? OVER : POINT;
            end else if (!hit_ok && nx > X_TOP) begin
               x_d    = X_LIM;
               sl_d   = score_l + SCORE_W'(1);
               pl_d   = 1'b1;
               hold_d = '0;
               st_d   = (sl_d == SCORE_WIN) ? OVER : POINT;
            end else begin
               x_d = nx[X_W-1:0];
            end
         end
         // dir_x still points at the side that conceded, so it is simply kept
         POINT: if (frame_tick) begin
            hold_d = hold + HOLD_W'(1);
            if (hold == HOLD_W'(HOLD_FR - 1)) begin
               x_d  = X_MID;
               y_d  = Y_MID;
               st_d = SERVE;
`ifdef BALL_ENGINE_SPEEDUP_EN
               spd_d = SPD_INIT;
`endif
            end
         end
         OVER: if (serve) begin
            sl_d = '0;
            sr_d = '0;
            x_d  = X_MID;
            y_d  = Y_MID;
            dx_d = 1'b0;
            st_d = SERVE;
`ifdef BALL_ENGINE_SPEEDUP_EN
            spd_d = SPD_INIT;
`endif
         end
         default: ;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) st <= SERVE;
      else          st <= st_d;
   end

   // ball, score, pulse and hold registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ball_x  <= X_MID;
         ball_y  <= Y_MID;
         dir_x   <= 1'b0;
         dir_y   <= 1'b0;
         score_l <= '0;
         score_r <= '0;
         point_l <= 1'b0;
         point_r <= 1'b0;
         hold    <= '0;
`ifdef BALL_ENGINE_SPEEDUP_EN
         speed   <= SPD_INIT;
`endif
      end else begin
         ball_x  <= x_d;
         ball_y  <= y_d;
         dir_x   <= dx_d;
         dir_y   <= dy_d;
         score_l <= sl_d;
         score_r <= sr_d;
         point_l <= pl_d;
         point_r <= pr_d;
         hold    <= hold_d;
`ifdef BALL_ENGINE_SPEEDUP_EN
         speed   <= spd_d;
`endif
      end
   end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed and randomized checks of ball_engine against an integer reference model.
module tb_ball_engine;
   localparam int XMAX = 632, YMAX = 472, CX = 316, CY = 236;
   localparam int INIT = 4, MAXS = 12, HOLD = 60, WIN = 9;
`ifdef BALL_ENGINE_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif

   logic       clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0, serve = 1'b0, hit_l = 1'b0, hit_r = 1'b0;
   logic [9:0] ball_x, ball_y;
   logic       dir_x, dir_y, point_l, point_r;
   logic [3:0] speed, score_l, score_r;
   logic [1:0] state;

   int checks = 0, errors = 0;
   int mx, my, mdx, mdy, mspd, msl, msr, mpl, mpr, mst, mticks, m_left_lost;

   always #5 clk = ~clk;

   ball_engine dut (
      .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .serve(serve),
      .hit_l(hit_l), .hit_r(hit_r), .ball_x(ball_x), .ball_y(ball_y),
      .dir_x(dir_x), .dir_y(dir_y), .speed(speed), .score_l(score_l),
      .score_r(score_r), .point_l(point_l), .point_r(point_r), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mx = CX; my = CY; mdx = 0; mdy = 0; mspd = INIT;
      msl = 0; msr = 0; mpl = 0; mpr = 0; mst = 0; mticks = 0; m_left_lost = 1;
   endtask

   task automatic model_step(input bit sv, input bit tk, input bit hl, input bit hr);
      bit hit;
      int nx, ny;
      mpl = 0;
      mpr = 0;
      if (mst == 0) begin
         if (sv) mst = 1;
      end else if (mst == 1) begin
         if (tk) begin
            hit = (hl && mdx == 0) || (hr && mdx == 1);
            if (hit) begin
               mdx = 1 - mdx;
               if (SPEEDUP && mspd < MAXS) mspd = mspd + 1;
            end
            nx = (mdx == 1) ? mx + mspd : mx - mspd;
            ny = (mdy == 1) ? my + mspd : my - mspd;
            if (ny < 0) begin my = 0; mdy = 1; end
            else if (ny > YMAX) begin my = YMAX; mdy = 0; end
            else my = ny;
            if (!hit && nx < 0) begin
               mx = 0; msr++; mpr = 1; mticks = 0; m_left_lost = 1;
               mst = (msr == WIN) ? 3 : 2;
            end else if (!hit && nx > XMAX) begin
               mx = XMAX; msl++; mpl = 1; mticks = 0; m_left_lost = 0;
               mst = (msl == WIN) ? 3 : 2;
            end else mx = nx;
         end
      end else if (mst == 2) begin
         if (tk) begin
            mticks++;
            if (mticks == HOLD) begin
               mx = CX; my = CY; mspd = INIT; mdx = m_left_lost ? 0 : 1; mst = 0;
            end
         end
      end else begin
         if (sv) begin
            msl = 0; msr = 0; mx = CX; my = CY; mspd = INIT; mdx = 0; mst = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("ball_x", ball_x, mx);
      chk("ball_y", ball_y, my);
      chk("dir_x", dir_x, mdx);
      chk("dir_y", dir_y, mdy);
      chk("speed", speed, mspd);
      chk("score_l", score_l, msl);
      chk("score_r", score_r, msr);
      chk("point_l", point_l, mpl);
      chk("point_r", point_r, mpr);
      chk("state", state, mst);
   endtask

   task automatic cycle(input bit sv, input bit tk, input bit hl, input bit hr);
      serve = sv; frame_tick = tk; hit_l = hl; hit_r = hr;
      @(posedge clk);
      model_step(sv, tk, hl, hr);
      @(negedge clk);
      check_all();
   endtask

   task automatic rally(input bit hl, output int n);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (state != 2'd0 && state != 2'd3 && n < 400) begin
         cycle(1'b0, 1'b1, hl, 1'b0);
         n++;
      end
      chk("rally_bound", n < 400, 1);
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset_n = 1'b1;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("serve_tick_ignored", ball_x, CX);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      chk("serve_to_play", state, 1);
      chk("serve_no_motion", ball_x, CX);
      for (int k = 1; k <= 3; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         chk("tp_x", ball_x, CX - 4 * k);
         chk("tp_y", ball_y, CY - 4 * k);
      end
      n = 0;
      while (state == 2'd1 && n < 200) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         n++;
      end
      chk("pt_state", state, 2);
      chk("pt_x", ball_x, 0);
      chk("pt_score_r", score_r, 1);
      chk("pt_pulse", point_r, 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pt_pulse_end", point_r, 0);
      repeat (HOLD - 1) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("hold_still_point", state, 2);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("hold_done_state", state, 0);
      chk("hold_done_x", ball_x, CX);
      chk("hold_done_dir", dir_x, 0);
      for (int r = 0; r < 12 && state != 2'd3; r++) rally(1'b0, n);
      chk("win_r_state", state, 3);
      chk("win_r_score", score_r, WIN);
      repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b1);
      chk("over_frozen", state, 3);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("over_clear_r", score_r, 0);
      chk("over_clear_state", state, 0);
      for (int r = 0; r < 12 && state != 2'd3; r++) rally(1'b1, n);
      chk("win_l_state", state, 3);
      chk("win_l_score", score_l, WIN);
      chk("win_l_x", ball_x, XMAX);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("over_clear_l", score_l, 0);
      repeat (12000)
         cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
      if (state == 2'd3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (state == 2'd2 && n < 200) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         n++;
      end
      if (state == 2'd0) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_rst_x", ball_x, CX);
      @(negedge clk);
      reset_n = 1'b1;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_no_motion", ball_x, CX);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
